// File: rtl/snake_pkg.sv
// Shared definitions for the snake field: geometry, 7-segment cell map and scanner states.
package snake_pkg;

    localparam int FIELD_ROWS = 7;
    localparam int FIELD_COLS = 21;

    localparam int SEG_ITEMS = 8;

    // Item order A, B, C, D, E, F, G, DP; the column offset is relative to 3*digit.
    localparam logic [2:0] SEG_ROW  [SEG_ITEMS] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd4, 3'd2, 3'd3, 3'd5};
    localparam logic [4:0] SEG_COFF [SEG_ITEMS] = '{5'd2, 5'd3, 5'd3, 5'd2, 5'd1, 5'd1, 5'd2, 5'd3};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        SHOW    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/seg_cell_map.sv
// Maps (digit, segment item) to the field cell that backs that segment.
module seg_cell_map
    import snake_pkg::*;
(
    input  logic [2:0] i_digit,
    input  logic [2:0] i_item,
    output logic [2:0] o_row,
    output logic [4:0] o_col
);

    logic [4:0] w_base_col;

    // At most 3*5+3 = 18 for six digits, so 5 bits never overflow.
    always_comb begin
        w_base_col = {2'b00, i_digit} * 5'd3;
        o_row      = SEG_ROW[i_item];
        o_col      = w_base_col + SEG_COFF[i_item];
    end

endmodule

// File: rtl/seg_field_scanner.sv
// Scans the snake field memory onto a bank of common-segment 7-segment digits,
// one digit at a time, with blanking while each digit's cells are fetched.
module seg_field_scanner
    import snake_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [2:0]            rd_row,
    output logic [4:0]            rd_col,
    input  logic                  rd_data,
    output logic                  segA,
    output logic                  segB,
    output logic                  segC,
    output logic                  segD,
    output logic                  segE,
    output logic                  segF,
    output logic                  segG,
    output logic                  segDP,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_done
);

    localparam int              CW         = $clog2(REFRESH_DIV + 1);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

    scan_state_e            r_state;
    logic [2:0]             r_digit;
    logic [2:0]             r_item;
    logic [CW-1:0]          r_dwell;
    logic [6:0]             r_shadow;
    logic [7:0]             r_seg;
    logic [NUM_DIGITS-1:0]  r_dig_n;
    logic                   r_frame_done;
    logic [2:0]             r_rd_row;
    logic [4:0]             r_rd_col;

    logic                   w_dwell_done;
    logic [2:0]             w_digit_next;
    logic [2:0]             w_map_digit;
    logic [2:0]             w_map_item;
    logic [2:0]             w_map_row;
    logic [4:0]             w_map_col;
    logic                   w_last_show_next;

    always_comb begin
        w_dwell_done = (r_state == SHOW) && (r_dwell == DWELL_LAST);
        w_digit_next = (r_digit == DIGIT_LAST) ? 3'd0 : r_digit + 3'd1;
        // The address register is loaded one edge ahead of the FETCH cycle that uses it.
        w_map_digit  = (r_state == SHOW) ? w_digit_next : r_digit;
        w_map_item   = (r_state == FETCH) ? r_item + 3'd1 : 3'd0;
        w_last_show_next = (r_digit == DIGIT_LAST) &&
            (((r_state == CAPTURE) && (DWELL_LAST == '0)) ||
             ((r_state == SHOW) && !w_dwell_done && ((r_dwell + CW'(1)) == DWELL_LAST)));
    end

    seg_cell_map u_map (
        .i_digit (w_map_digit),
        .i_item  (w_map_item),
        .o_row   (w_map_row),
        .o_col   (w_map_col)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_digit      <= '0;
            r_item       <= '0;
            r_dwell      <= '0;
            r_shadow     <= '1;
            r_seg        <= '1;
            r_dig_n      <= '1;
            r_frame_done <= 1'b0;
            r_rd_row     <= '0;
            r_rd_col     <= '0;
        end else if (!en) begin
            r_state      <= IDLE;
            r_digit      <= '0;
            r_item       <= '0;
            r_dwell      <= '0;
            r_seg        <= '1;
            r_dig_n      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_show_next;
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH;
                    r_item   <= '0;
                    r_rd_row <= w_map_row;
                    r_rd_col <= w_map_col;
                end
                FETCH: begin
                    // Data for item k-1 arrives while item k is addressed.
                    if (r_item != 3'd0) begin
                        r_shadow <= {rd_data, r_shadow[6:1]};
                    end
                    if (r_item == 3'd7) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_item   <= r_item + 3'd1;
                        r_rd_row <= w_map_row;
                        r_rd_col <= w_map_col;
                    end
                end
                CAPTURE: begin
                    r_seg   <= {rd_data, r_shadow};
                    r_dig_n <= ~(NUM_DIGITS'(1) << r_digit);
                    r_dwell <= '0;
                    r_state <= SHOW;
                end
                SHOW: begin
                    if (w_dwell_done) begin
                        r_seg    <= '1;
                        r_dig_n  <= '1;
                        r_dwell  <= '0;
                        r_digit  <= w_digit_next;
                        r_item   <= '0;
                        r_rd_row <= w_map_row;
                        r_rd_col <= w_map_col;
                        r_state  <= FETCH;
                    end else begin
                        r_dwell <= r_dwell + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_row     = r_rd_row;
    assign rd_col     = r_rd_col;
    assign segA       = r_seg[0];
    assign segB       = r_seg[1];
    assign segC       = r_seg[2];
    assign segD       = r_seg[3];
    assign segE       = r_seg[4];
    assign segF       = r_seg[5];
    assign segG       = r_seg[6];
    assign segDP      = r_seg[7];
    assign dig_n      = r_dig_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_field_scanner.sv
// Directed bench for seg_field_scanner: cycle-by-cycle expectations from a small field model.
module tb_seg_field_scanner;

    localparam int ND  = 6;
    localparam int RD  = 4;
    localparam int PER = RD + 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    rd_row;
    logic [4:0]    rd_col;
    logic          rd_data;
    logic          segA, segB, segC, segD, segE, segF, segG, segDP;
    logic [ND-1:0] dig_n;
    logic          frame_done;

    logic          fld [0:6][0:20];
    logic [7:0]    pat [0:ND-1];
    int            rowt [8] = '{1, 2, 4, 5, 4, 2, 3, 5};
    int            offt [8] = '{2, 3, 3, 2, 1, 1, 2, 3};
    int            n_chk  = 0;
    int            n_pass = 0;

    seg_field_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .segA       (segA),
        .segB       (segB),
        .segC       (segC),
        .segD       (segD),
        .segE       (segE),
        .segF       (segF),
        .segG       (segG),
        .segDP      (segDP),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous field memory: data valid one cycle after the address.
    always @(posedge clk) rd_data <= fld[rd_row][rd_col];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] seg_vec();
        return {segDP, segG, segF, segE, segD, segC, segB, segA};
    endfunction

    // Runs from "cycle 0" (just after an edge with en high) and checks every cycle.
    task automatic run(input int ncyc, input int flip_at);
        for (int c = 1; c <= ncyc; c++) begin
            int p, d, it;
            logic [7:0]    exp_seg;
            logic [ND-1:0] exp_dig;
            @(posedge clk); #1;
            p  = (c - 1) % PER;
            d  = ((c - 1) / PER) % ND;
            it = (p < 8) ? p : 7;
            if (p == 8) begin
                for (int k = 0; k < 8; k++) pat[d][k] = fld[rowt[k]][3 * d + offt[k]];
            end
            if (p >= 9) begin
                exp_seg = pat[d];
                exp_dig = ~(ND'(1) << d);
            end else begin
                exp_seg = '1;
                exp_dig = '1;
            end
            check($sformatf("addr c%0d", c), {rd_row, rd_col}, {3'(rowt[it]), 5'(3 * d + offt[it])});
            check($sformatf("seg c%0d", c), seg_vec(), exp_seg);
            check($sformatf("dig_n c%0d", c), dig_n, exp_dig);
            check($sformatf("frame_done c%0d", c), frame_done, (d == ND - 1 && p == PER - 1));
            if (c == flip_at) fld[1][2] = 1'b1;
        end
    endtask

    initial begin
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 21; k++) fld[r][k] = 1'b1;
        fld[1][2] = 1'b0;
        fld[2][6] = 1'b0;
        fld[4][6] = 1'b0;
        fld[3][5] = 1'b0;

        rst_n = 1'b1;
        en    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst seg", seg_vec(), 8'hFF);
        check("rst dig_n", dig_n, {ND{1'b1}});
        check("rst addr", {rd_row, rd_col}, 8'h00);
        check("rst frame_done", frame_done, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // Hand values: digit 0 lights segA only, digit 1 lights B, C, G.
        run(10, 0);
        check("d0 seg hand", seg_vec(), 8'b1111_1110);
        check("d0 dig_n hand", dig_n, 6'b111110);
        run(0, 0);

        // Re-align: continue the model from cycle 11 by restarting numbering is not
        // possible, so finish the long run with the flip of (1,2) during digit 0 SHOW.
        for (int c = 11; c <= 245; c++) begin
            int p, d, it;
            logic [7:0]    exp_seg;
            logic [ND-1:0] exp_dig;
            @(posedge clk); #1;
            p  = (c - 1) % PER;
            d  = ((c - 1) / PER) % ND;
            it = (p < 8) ? p : 7;
            if (p == 8) begin
                for (int k = 0; k < 8; k++) pat[d][k] = fld[rowt[k]][3 * d + offt[k]];
            end
            if (p >= 9) begin
                exp_seg = pat[d];
                exp_dig = ~(ND'(1) << d);
            end else begin
                exp_seg = '1;
                exp_dig = '1;
            end
            check($sformatf("addr c%0d", c), {rd_row, rd_col}, {3'(rowt[it]), 5'(3 * d + offt[it])});
            check($sformatf("seg c%0d", c), seg_vec(), exp_seg);
            check($sformatf("dig_n c%0d", c), dig_n, exp_dig);
            check($sformatf("frame_done c%0d", c), frame_done, (d == ND - 1 && p == PER - 1));
            if (c == 23) begin
                check("d1 seg hand", seg_vec(), 8'b1011_1001);
                check("d1 dig_n hand", dig_n, 6'b111101);
            end
            if (c == 91) check("segA held after flip", segA, 1'b0);
            if (c == 166) check("segA updated next frame", segA, 1'b1);
            if (c == 89) fld[1][2] = 1'b1;
        end

        // Now mid-SHOW of digit 0; dropping en blanks on the next edge.
        check("show before en low", dig_n, 6'b111110);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("en low seg", seg_vec(), 8'hFF);
            check("en low dig_n", dig_n, {ND{1'b1}});
            check("en low frame_done", frame_done, 1'b0);
            check("en low addr hold", {rd_row, rd_col}, {3'd5, 5'd3});
        end
        fld[1][2] = 1'b0;
        en = 1'b1;
        run(23, 0);

        // Mid-SHOW of digit 1: async reset blanks with no clock edge.
        check("d1 lit before reset", dig_n, 6'b111101);
        #2 rst_n = 1'b0;
        #1;
        check("async rst seg", seg_vec(), 8'hFF);
        check("async rst dig_n", dig_n, {ND{1'b1}});
        check("async rst addr", {rd_row, rd_col}, 8'h00);
        check("async rst frame_done", frame_done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
